// File: rtl/image_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : image_receiver_if
// Summary  : Serial input and frame-buffer write port of the image receiver.
//            The master is the receiver, and the slave is the serial source
//            plus the frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
interface image_receiver_if;
  logic        uart_in;
  logic        wr_en;
  logic [16:0] wr_address;
  logic [11:0] wr_data;
  logic        frame_active;
  logic        frame_done;
  logic        rx_error;

  modport master (
    input  uart_in,
    output wr_en, wr_address, wr_data, frame_active, frame_done, rx_error
  );

  modport slave (
    output uart_in,
    input  wr_en, wr_address, wr_data, frame_active, frame_done, rx_error
  );
endinterface
`default_nettype wire

// File: rtl/image_receiver.sv
`default_nettype none
// ============================================================================
// Module   : image_receiver
// Summary  : 8N1 UART receiver that reassembles RGB444 pixels. It locks on the
//            frame-start marker pixel and writes each frame into a frame buffer.
// Revision : 1.0 - initial release
// ============================================================================
module image_receiver #(
  parameter int          CLK_FREQ     = 50000000,
  parameter int          BAUD_RATE    = 115200,
  parameter int          NUM_PIXELS   = 76800,
  parameter logic [11:0] START_PIXEL  = 12'h00A,
  parameter int          TIMEOUT_CLKS = 50000
) (
  input  wire logic        clk,
  input  wire logic        rst,
  image_receiver_if.master fb
);

  localparam int c_clks_per_bit = CLK_FREQ / BAUD_RATE;
  localparam int c_cnt_w        = (c_clks_per_bit > 1) ? $clog2(c_clks_per_bit) : 1;
  localparam int c_idle_w       = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [c_cnt_w-1:0]  c_half_m1    = c_cnt_w'(c_clks_per_bit / 2 - 1);
  localparam logic [c_cnt_w-1:0]  c_full_m1    = c_cnt_w'(c_clks_per_bit - 1);
  localparam logic [c_idle_w-1:0] c_timeout_m1 = c_idle_w'(TIMEOUT_CLKS - 1);
  localparam logic [16:0]         c_last_addr  = 17'(NUM_PIXELS - 1);

  // Byte FSM encoding
  localparam logic [2:0] c_bs_idle  = 3'd0;
  localparam logic [2:0] c_bs_start = 3'd1;
  localparam logic [2:0] c_bs_data  = 3'd2;
  localparam logic [2:0] c_bs_stop  = 3'd3;
  localparam logic [2:0] c_bs_wait  = 3'd4;

  // Frame FSM encoding
  localparam logic [0:0] c_fs_hunt = 1'b0;
  localparam logic [0:0] c_fs_recv = 1'b1;

  logic                r_sync1, r_sync2;
  logic [2:0]          r_bs, w_bs_next;
  logic [c_cnt_w-1:0]  r_baud_cnt;
  logic [2:0]          r_bit_idx;
  logic [7:0]          r_shift;
  logic                w_half, w_full;
  logic                w_byte_valid, w_frame_err;
  logic [7:0]          w_rx_byte;

  logic [0:0]          r_fs, w_fs_next;
  logic [7:0]          r_win;
  logic                r_win_vld;
  logic                r_phase_lo;
  logic [3:0]          r_hi;
  logic [16:0]         r_addr;
  logic [c_idle_w-1:0] r_idle_cnt;
  logic                r_done_pend;
  logic                w_marker, w_lock, w_hi_byte, w_bad_hi, w_pix_wr;
  logic                w_last, w_timeout, w_abort;

  logic                r_wr_en;
  logic [16:0]         r_wr_address;
  logic [11:0]         r_wr_data;
  logic                r_frame_active;
  logic                r_frame_done;
  logic                r_rx_error;

  assign w_half    = (r_baud_cnt == c_half_m1);
  assign w_full    = (r_baud_cnt == c_full_m1);
  assign w_rx_byte = r_shift;

  // Two-flop synchroniser on the asynchronous line. It resets to the idle-high level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= fb.uart_in;
      r_sync2 <= r_sync1;
    end
  end

  // Byte FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_bs <= c_bs_idle;
    else     r_bs <= w_bs_next;
  end

  // Byte FSM next state. START rechecks at mid-bit so that short glitches are dropped.
  always_comb begin
    w_bs_next = r_bs;
    case (r_bs)
      c_bs_idle:  if (!r_sync2) w_bs_next = c_bs_start;
      c_bs_start: if (w_half) w_bs_next = r_sync2 ? c_bs_idle : c_bs_data;
      c_bs_data:  if (w_full && (r_bit_idx == 3'd7)) w_bs_next = c_bs_stop;
      c_bs_stop:  if (w_full) w_bs_next = r_sync2 ? c_bs_idle : c_bs_wait;
      c_bs_wait:  if (r_sync2) w_bs_next = c_bs_idle;
      default:    w_bs_next = c_bs_idle;
    endcase
  end

  // Byte FSM outputs: the stop-bit sample either delivers the byte or flags a framing error
  always_comb begin
    w_byte_valid = 1'b0;
    w_frame_err  = 1'b0;
    if ((r_bs == c_bs_stop) && w_full) begin
      w_byte_valid = r_sync2;
      w_frame_err  = !r_sync2;
    end
  end

  // Bit timing and LSB-first shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      if ((w_bs_next != r_bs) || (r_bs == c_bs_idle) || (r_bs == c_bs_wait) ||
          ((r_bs == c_bs_data) && w_full))
        r_baud_cnt <= '0;
      else
        r_baud_cnt <= r_baud_cnt + c_cnt_w'(1);

      if (r_bs == c_bs_start) begin
        r_bit_idx <= '0;
      end else if ((r_bs == c_bs_data) && w_full) begin
        r_shift   <= {r_sync2, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
    end
  end

  // Frame FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_fs <= c_fs_hunt;
    else     r_fs <= w_fs_next;
  end

  // Frame FSM next state
  always_comb begin
    w_fs_next = r_fs;
    if (r_fs == c_fs_hunt) begin
      if (w_lock) w_fs_next = c_fs_recv;
    end else begin
      if (w_abort || w_last) w_fs_next = c_fs_hunt;
    end
  end

  // Frame FSM decode: marker detection, pixel phase, abort conditions
  always_comb begin
    w_marker  = r_win_vld && (r_win[7:4] == 4'h0) && ({r_win[3:0], w_rx_byte} == START_PIXEL);
    w_lock    = (r_fs == c_fs_hunt) && w_byte_valid && w_marker;
    w_hi_byte = (r_fs == c_fs_recv) && w_byte_valid && !r_phase_lo;
    w_bad_hi  = w_hi_byte && (w_rx_byte[7:4] != 4'h0);
    w_pix_wr  = (r_fs == c_fs_recv) && w_byte_valid && r_phase_lo;
    w_last    = w_pix_wr && (r_addr == c_last_addr);
    w_timeout = (r_fs == c_fs_recv) && (r_bs == c_bs_idle) && (r_idle_cnt == c_timeout_m1);
    w_abort   = (r_fs == c_fs_recv) && (w_bad_hi || w_frame_err || w_timeout);
  end

  // Frame datapath: sliding marker window, pixel assembly, write port, status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win          <= '0;
      r_win_vld      <= 1'b0;
      r_phase_lo     <= 1'b0;
      r_hi           <= '0;
      r_addr         <= '0;
      r_idle_cnt     <= '0;
      r_done_pend    <= 1'b0;
      r_wr_en        <= 1'b0;
      r_wr_address   <= '0;
      r_wr_data      <= '0;
      r_frame_active <= 1'b0;
      r_frame_done   <= 1'b0;
      r_rx_error     <= 1'b0;
    end else begin
      r_wr_en      <= 1'b0;
      r_done_pend  <= 1'b0;
      r_frame_done <= r_done_pend;
      r_rx_error   <= w_frame_err || w_bad_hi || w_timeout;
      if (r_done_pend) r_frame_active <= 1'b0;

      // A lost byte breaks the window. A rejected high byte may still start a marker.
      if (w_frame_err) begin
        r_win_vld <= 1'b0;
      end else if (w_byte_valid && ((r_fs == c_fs_hunt) || w_bad_hi)) begin
        r_win     <= w_rx_byte;
        r_win_vld <= 1'b1;
      end

      if (w_abort) r_frame_active <= 1'b0;

      if (w_hi_byte && !w_bad_hi) begin
        r_hi       <= w_rx_byte[3:0];
        r_phase_lo <= 1'b1;
      end

      if (w_pix_wr) begin
        r_wr_en      <= 1'b1;
        r_wr_address <= r_addr;
        r_wr_data    <= {r_hi, w_rx_byte};
        r_phase_lo   <= 1'b0;
        if (w_last) r_done_pend <= 1'b1;
        else        r_addr      <= r_addr + 17'd1;
      end

      if (w_lock) begin
        r_wr_en        <= 1'b1;
        r_wr_address   <= '0;
        r_wr_data      <= START_PIXEL;
        r_frame_active <= 1'b1;
        r_addr         <= 17'd1;
        r_phase_lo     <= 1'b0;
        r_win_vld      <= 1'b0;
      end

      // Idle clocks since the last byte. This counter runs only in RECV while the line is quiet.
      if ((r_fs != c_fs_recv) || w_byte_valid)
        r_idle_cnt <= '0;
      else if (r_bs == c_bs_idle)
        r_idle_cnt <= r_idle_cnt + c_idle_w'(1);
    end
  end

  assign fb.wr_en        = r_wr_en;
  assign fb.wr_address   = r_wr_address;
  assign fb.wr_data      = r_wr_data;
  assign fb.frame_active = r_frame_active;
  assign fb.frame_done   = r_frame_done;
  assign fb.rx_error     = r_rx_error;

endmodule
`default_nettype wire

// File: tb/tb_image_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_receiver
// Summary  : Directed and randomized frames checked against a byte-stream
//            decoder model of the image link.
// Revision : 1.0 - initial release
// ============================================================================
module tb_image_receiver;

  localparam int          c_clk_freq    = 1_600_000;
  localparam int          c_baud        = 100_000;
  localparam int          c_cpb         = c_clk_freq / c_baud;
  localparam int          c_num_pixels  = 4;
  localparam logic [11:0] c_start_pixel = 12'h00A;
  localparam int          c_timeout     = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;

  image_receiver_if fb ();

  image_receiver #(
    .CLK_FREQ     (c_clk_freq),
    .BAUD_RATE    (c_baud),
    .NUM_PIXELS   (c_num_pixels),
    .START_PIXEL  (c_start_pixel),
    .TIMEOUT_CLKS (c_timeout)
  ) dut (
    .clk (clk),
    .rst (rst),
    .fb  (fb)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Observed traffic on the write port and status pulses
  int          cyc = 0;
  logic [28:0] got_q[$];
  int          got_done = 0, got_err = 0;
  int          last_wr_cyc = 0, last_err_cyc = 0;
  int          wr_inactive = 0;
  logic        prev_act = 1'b0, done_act = 1'b0, done_prev_act = 1'b0;

  // Capture outputs on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    cyc      <= cyc + 1;
    prev_act <= fb.frame_active;
    if (fb.wr_en) begin
      got_q.push_back({fb.wr_address, fb.wr_data});
      last_wr_cyc <= cyc;
      if (!fb.frame_active) wr_inactive <= wr_inactive + 1;
    end
    if (fb.frame_done) begin
      got_done      <= got_done + 1;
      done_act      <= fb.frame_active;
      done_prev_act <= prev_act;
    end
    if (fb.rx_error) begin
      got_err      <= got_err + 1;
      last_err_cyc <= cyc;
    end
  end

  // Reference decoder: consumes whole bytes and predicts the writes of the link
  bit          m_lock = 1'b0;
  bit [7:0]    m_win = 8'h00;
  bit          m_win_vld = 1'b0;
  int          m_next = 0;
  bit          m_want_lo = 1'b0;
  int          m_hi = 0;
  logic [28:0] exp_q[$];
  int          exp_done = 0, exp_err = 0;

  task automatic model_byte(input logic [7:0] b, input bit stop_ok);
    int pix;
    if (!stop_ok) begin
      exp_err++;
      m_lock    = 1'b0;
      m_win_vld = 1'b0;
    end else if (!m_lock) begin
      if (m_win_vld && (int'(m_win) * 256 + int'(b)) == int'(c_start_pixel)) begin
        exp_q.push_back({17'd0, c_start_pixel});
        m_lock    = 1'b1;
        m_next    = 1;
        m_want_lo = 1'b0;
        m_win_vld = 1'b0;
      end else begin
        m_win     = b;
        m_win_vld = 1'b1;
      end
    end else if (!m_want_lo) begin
      if (b > 8'h0F) begin
        exp_err++;
        m_lock    = 1'b0;
        m_win     = b;
        m_win_vld = 1'b1;
      end else begin
        m_hi      = int'(b);
        m_want_lo = 1'b1;
      end
    end else begin
      pix = m_hi * 256 + int'(b);
      exp_q.push_back({17'(m_next), 12'(pix)});
      m_want_lo = 1'b0;
      if (m_next == c_num_pixels - 1) begin
        exp_done++;
        m_lock = 1'b0;
      end else begin
        m_next++;
      end
    end
  endtask

  task automatic model_timeout();
    if (m_lock) begin
      exp_err++;
      m_lock = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_lock    = 1'b0;
    m_win_vld = 1'b0;
    m_want_lo = 1'b0;
    exp_q.delete();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int rgap();
    return int'($urandom_range(40, 1));
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit stop_ok, input int gap);
    fb.uart_in = 1'b0;
    repeat (c_cpb) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      fb.uart_in = b[i];
      repeat (c_cpb) @(negedge clk);
    end
    fb.uart_in = stop_ok;
    repeat (c_cpb) @(negedge clk);
    fb.uart_in = 1'b1;
    repeat (gap) @(negedge clk);
    model_byte(b, stop_ok);
  endtask

  task automatic send_pixel(input logic [11:0] p, input int gap);
    send_byte({4'h0, p[11:8]}, 1'b1, gap);
    send_byte(p[7:0], 1'b1, gap);
  endtask

  task automatic send_frame();
    send_pixel(c_start_pixel, rgap());
    for (int p = 1; p < c_num_pixels; p++) send_pixel(12'($urandom), rgap());
  endtask

  task automatic check_scenario(input string tag);
    int n;
    repeat (60) @(negedge clk);
    #1;
    check({tag, ".nwr"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, ".wr"}, 32'(got_q[i]), 32'(exp_q[i]));
    check({tag, ".done"}, got_done, exp_done);
    check({tag, ".err"}, got_err, exp_err);
    check({tag, ".active"}, 32'(fb.frame_active), 32'(m_lock));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int ng;
    fb.uart_in = 1'b1;
    rst        = 1'b1;
    repeat (3) @(negedge clk);
    check("rst.wr_en",  32'(fb.wr_en), 0);
    check("rst.addr",   32'(fb.wr_address), 0);
    check("rst.data",   32'(fb.wr_data), 0);
    check("rst.active", 32'(fb.frame_active), 0);
    check("rst.done",   32'(fb.frame_done), 0);
    check("rst.err",    32'(fb.rx_error), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Basic frame with fixed pixels
    send_pixel(c_start_pixel, 4);
    send_pixel(12'h123, 4);
    send_pixel(12'h456, 4);
    send_pixel(12'hFFF, 4);
    check_scenario("t1");
    check("t1.done_act", 32'(done_act), 0);
    check("t1.prev_act", 32'(done_prev_act), 1);

    // Garbage byte ahead of the marker
    send_byte(8'h7A, 1'b1, 6);
    send_frame();
    check_scenario("garbage");

    // Random frames, including random garbage prefixes and a marker value inside the data
    for (int f = 0; f < 3; f++) begin
      ng = int'($urandom_range(2, 0));
      for (int g = 0; g < ng; g++) send_byte(8'($urandom) | 8'h80, 1'b1, rgap());
      send_pixel(c_start_pixel, rgap());
      send_pixel(12'($urandom), rgap());
      send_pixel((f == 0) ? c_start_pixel : 12'($urandom), rgap());
      send_pixel(12'($urandom), rgap());
      check_scenario("rand");
    end

    // Framing error mid-frame, then recovery
    send_pixel(c_start_pixel, 4);
    send_pixel(12'h3C5, 4);
    send_byte(8'h07, 1'b0, 2 * c_cpb);
    check_scenario("ferr");
    send_frame();
    check_scenario("ferr_rec");

    // Bad high byte mid-frame
    send_pixel(c_start_pixel, 4);
    send_pixel(12'h2B7, 4);
    send_byte(8'h5A, 1'b1, 4);
    check_scenario("badhi");

    // Timeout after pixel 1
    send_pixel(c_start_pixel, 4);
    send_pixel(12'hABC, 4);
    repeat (c_timeout + 100) @(negedge clk);
    model_timeout();
    check_scenario("tmo");
    check("tmo.dist", last_err_cyc - last_wr_cyc, c_timeout);

    // Short low glitch on an idle line, then a normal frame
    fb.uart_in = 1'b0;
    repeat (5) @(negedge clk);
    fb.uart_in = 1'b1;
    check_scenario("glitch");
    send_frame();
    check_scenario("glitch_rx");

    // Reset mid-frame, then a fresh frame
    send_pixel(c_start_pixel, 4);
    send_pixel(12'h9E1, 4);
    check_scenario("pre_rst");
    rst = 1'b1;
    @(negedge clk);
    check("mrst.wr_en",  32'(fb.wr_en), 0);
    check("mrst.addr",   32'(fb.wr_address), 0);
    check("mrst.data",   32'(fb.wr_data), 0);
    check("mrst.active", 32'(fb.frame_active), 0);
    rst = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    send_frame();
    check_scenario("post_rst");

    check("wr_while_inactive", wr_inactive, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/image_receiver.md
Name: image_receiver

Overview:
- UART receive end of the camera-image link. Deserialises the 8N1 byte stream produced by the image sender and reassembles 12-bit RGB444 pixels.
- Locks onto the frame-start marker pixel, then drives a write port (address, data, enable) into a 320x240 frame buffer.
- Used on the receiving board, or in loopback, to validate the wifi/UART image path.

Parameters:
- CLK_FREQ, 50000000, clk frequency in Hz.
- BAUD_RATE, 115200, line rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division, 434 at defaults).
- NUM_PIXELS, 76800, pixels per frame (320*240).
- START_PIXEL, 12'h00A, marker value sent in place of pixel 0.
- TIMEOUT_CLKS, 50000, maximum idle clocks between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- rst  in  1  synchronous, active-high reset.
- uart_in  in  1  asynchronous serial line, idle high.
- wr_en  out  1  one-cycle write strobe to the frame buffer.
- wr_address  out  17  pixel address, 0..NUM_PIXELS-1.
- wr_data  out  12  pixel value {R[3:0],G[3:0],B[3:0]}.
- frame_active  out  1  high while locked and receiving a frame.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written.
- rx_error  out  1  one-cycle pulse on a framing error, a bad high byte, or a timeout abort.

Behaviour:
- Reset: all outputs are 0. Both FSMs return to idle/HUNT. All counters and byte registers are cleared. Reset mid-frame discards the partial frame; no frame_done is issued.
- Input: uart_in passes through a 2-flop synchroniser; the FSM uses only the synchronised value.
- Byte FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE -> START on synchronised line low.
  - START: after CLKS_PER_BIT/2 clocks, resample. If low -> DATA. If high (glitch) -> IDLE, with no error.
  - DATA: sample every CLKS_PER_BIT clocks, 8 bits, LSB first -> STOP.
  - STOP: sample after CLKS_PER_BIT clocks. If high, pulse the internal byte_valid in that cycle -> IDLE. If low, pulse rx_error, discard the byte -> WAIT_HIGH.
  - WAIT_HIGH -> IDLE once the line reads high.
- Pixel encoding: 2 bytes per pixel, high byte first. Byte H = {4'b0000, pix[11:8]}, byte L = pix[7:0].
- Frame FSM states: HUNT, RECV.
  - HUNT: keep the last two bytes as a sliding window (prev, cur). When prev[7:4]==0 and {prev[3:0],cur}==START_PIXEL:
    - write START_PIXEL to address 0 (wr_en the cycle after the byte_valid of cur);
    - set frame_active, set the next address to 1, set the phase to expect H -> RECV.
  - RECV: bytes alternate H/L.
    - An H byte with a nonzero upper nibble pulses rx_error, aborts the frame and goes -> HUNT. The window is seeded with that byte, so it can still begin a marker.
    - On each L byte, wr_data={H[3:0],L} and wr_address=current address, with wr_en high for exactly one cycle, one clock after that byte_valid. The address then increments.
  - After the write to address NUM_PIXELS-1: frame_done pulses in the cycle after that wr_en, frame_active clears -> HUNT.
  - A framing error in RECV aborts the frame (rx_error, -> HUNT, frame_active=0, no frame_done).
  - Timeout: in RECV with the byte FSM idle, an idle counter counts clocks since the last byte_valid. When it reaches TIMEOUT_CLKS: rx_error pulses, frame_active=0, state -> HUNT.
- Marker values inside image data are ignored while in RECV. A false lock in HUNT is resolved by the timeout or at frame end.
- wr_address and wr_data hold their last values when wr_en=0. The address never exceeds NUM_PIXELS-1 (no wrap-around).
- Latency: the last line edge of the L stop bit-centre sample is followed by wr_en one clock later.

Test Plan:
- NUM_PIXELS=4, send bytes 00 0A 01 23 04 56 0F FF -> writes (0,00A),(1,123),(2,456),(3,FFF), then one frame_done pulse. frame_active is high from the first write until the cycle frame_done asserts.
- Send garbage byte 7A, then 00 0A plus 3 pixels -> the marker still locks from the sliding window and 4 writes occur. No write happens before the marker.
- Mid-frame stop bit forced low -> rx_error pulse, frame_active=0, no frame_done. A subsequent clean frame is received correctly.
- Stop sending after pixel 1 -> rx_error after exactly TIMEOUT_CLKS idle clocks, return to HUNT, no further writes.
- 100-clock low glitch on an idle line -> no byte, no error. Then a valid byte at 115200 baud is received intact.
- Assert rst mid-frame -> all outputs 0 next cycle. A fresh frame afterwards writes starting at address 0.
